keystream_generator: RTL and testbench

KEYSTREAM_GENERATOR -- requirements
Module: keystream_generator

---
 rtl/keystream_generator.sv | 113 +++++++++++
 tb/tb_keystream_generator.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/keystream_generator.sv
// Xorshift32 keystream generator: a 4-byte key seeds the state, and each request
// yields one byte after three shift/xor steps. Accepts one pending request while busy.
module keystream_generator #(
   parameter logic [31:0] ZERO_SEED = 32'h2545_F491
) (
   input  logic       clk,
   input  logic       nrst,
   input  logic [7:0] key_byte,
   input  logic       key_byte_pulse,
   input  logic       request_byte_pulse,
   output logic [7:0] hash_byte,
   output logic       hash_byte_pulse,
   output logic       ready,
   output logic       overrun
);

   localparam int unsigned XW = 32;

   typedef enum logic [2:0] {
      LOAD  = 3'd0,
      READY = 3'd1,
      S1    = 3'd2,
      S2    = 3'd3,
      S3    = 3'd4,
      OUT   = 3'd5
   } state_t;

   state_t          state;
   logic [XW-1:0]   x;
   logic [1:0]      cnt;
   logic            pending;

   // Incoming key bytes enter at the top so byte 0 ends up in x[7:0]
   logic [XW-1:0] x_shift;
   logic [XW-1:0] x_s1;
   logic [XW-1:0] x_s2;
   logic [XW-1:0] x_s3;

   assign x_shift = {key_byte, x[XW-1:8]};
   assign x_s1    = x ^ (x << 13);
   assign x_s2    = x ^ (x >> 17);
   assign x_s3    = x ^ (x << 5);

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state           <= LOAD;
         x               <= '0;
         cnt             <= 2'd0;
         pending         <= 1'b0;
         hash_byte       <= 8'h00;
         hash_byte_pulse <= 1'b0;
         ready           <= 1'b0;
         overrun         <= 1'b0;
      end else begin
         hash_byte_pulse <= 1'b0;
         if (key_byte_pulse) begin
            // Key bytes win over everything: any generation in flight is abandoned
            pending <= 1'b0;
            if (state == LOAD && cnt == 2'd3) begin
               state <= READY;
               ready <= 1'b1;
               cnt   <= 2'd0;
               x     <= (x_shift == '0) ? ZERO_SEED : x_shift;
            end else begin
               state <= LOAD;
               ready <= 1'b0;
               x     <= x_shift;
               cnt   <= (state == LOAD) ? cnt + 2'd1 : 2'd1;
            end
         end else begin
            case (state)
               LOAD: begin
               end
               READY: begin
                  if (request_byte_pulse) state <= S1;
               end
               S1, S2, S3: begin
                  if (request_byte_pulse) begin
                     if (pending) overrun <= 1'b1;
                     else         pending <= 1'b1;
                  end
                  if (state == S1) begin
                     x     <= x_s1;
                     state <= S2;
                  end else if (state == S2) begin
                     x     <= x_s2;
                     state <= S3;
                  end else begin
                     x               <= x_s3;
                     hash_byte       <= x_s3[7:0] ^ x_s3[31:24];
                     hash_byte_pulse <= 1'b1;
                     state           <= OUT;
                  end
               end
               OUT: begin
                  // A request in OUT either starts immediately or, if one is queued, takes its place
                  if (pending || request_byte_pulse) begin
                     state   <= S1;
                     pending <= pending & request_byte_pulse;
                  end else begin
                     state <= READY;
                  end
               end
               default: begin
                  state <= LOAD;
                  ready <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_keystream_generator.sv
// Directed bench for keystream_generator: expected bytes and their due cycles are
// queued when a request is driven and checked as pulses appear.
module tb_keystream_generator;

   logic       clk = 1'b0;
   logic       nrst;
   logic [7:0] key_byte;
   logic       key_byte_pulse;
   logic       request_byte_pulse;
   logic [7:0] hash_byte;
   logic       hash_byte_pulse;
   logic       ready;
   logic       overrun;

   keystream_generator dut (
      .clk                (clk),
      .nrst               (nrst),
      .key_byte           (key_byte),
      .key_byte_pulse     (key_byte_pulse),
      .request_byte_pulse (request_byte_pulse),
      .hash_byte          (hash_byte),
      .hash_byte_pulse    (hash_byte_pulse),
      .ready              (ready),
      .overrun            (overrun)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] data;
      int         due;
   } exp_t;

   exp_t        q[$];
   int          checks   = 0;
   int          errors   = 0;
   int          cyc      = 0;
   int          last_due = 0;
   logic [31:0] mx      = 32'h0;

   function automatic logic [31:0] xs(input logic [31:0] v);
      logic [31:0] t;
      t = v;
      t = t ^ (t << 13);
      t = t ^ (t >> 17);
      t = t ^ (t << 5);
      return t;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   // One clock; afterwards the pulse is checked against the scoreboard head
   task automatic tick();
      logic exp_pulse;
      exp_t e;
      @(posedge clk);
      cyc++;
      #1;
      exp_pulse = (q.size() > 0) && (q[0].due == cyc);
      check("pulse", 32'(hash_byte_pulse), 32'(exp_pulse));
      if (exp_pulse) begin
         e = q.pop_front();
         if (hash_byte_pulse) check("hash_byte", 32'(hash_byte), 32'(e.data));
      end
   endtask

   task automatic key(input logic [7:0] b);
      key_byte       = b;
      key_byte_pulse = 1'b1;
      tick();
      key_byte_pulse = 1'b0;
   endtask

   task automatic load_key(input logic [7:0] b0, input logic [7:0] b1,
                           input logic [7:0] b2, input logic [7:0] b3);
      key(b0);
      key(b1);
      key(b2);
      check("ready_before_4th", 32'(ready), 32'd0);
      key(b3);
      check("ready_after_4th", 32'(ready), 32'd1);
      mx       = {b3, b2, b1, b0};
      if (mx == 32'h0) mx = 32'h2545_F491;
      last_due = 0;
   endtask

   // push=1 queues an expected byte; otherwise the request must yield nothing
   task automatic request(input bit push, input logic [7:0] expd);
      int due;
      if (push) begin
         due      = (last_due + 4 > cyc + 4) ? last_due + 4 : cyc + 4;
         q.push_back('{expd, due});
         last_due = due;
      end
      request_byte_pulse = 1'b1;
      tick();
      request_byte_pulse = 1'b0;
   endtask

   task automatic req_const(input logic [7:0] expd);
      mx = xs(mx);
      request(1'b1, expd);
   endtask

   task automatic req_model();
      mx = xs(mx);
      request(1'b1, mx[7:0] ^ mx[31:24]);
   endtask

   task automatic drain();
      for (int i = 0; i < 40 && q.size() > 0; i++) tick();
      check("queue_drained", 32'(q.size()), 32'd0);
      repeat (2) tick();
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_hash_byte"}, 32'(hash_byte), 32'h00);
      check({tag, "_pulse"},     32'(hash_byte_pulse), 32'd0);
      check({tag, "_ready"},     32'(ready), 32'd0);
      check({tag, "_overrun"},   32'(overrun), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL timeout");
      $fatal(1, "bench did not finish");
   end

   initial begin
      nrst               = 1'b0;
      key_byte           = 8'h00;
      key_byte_pulse     = 1'b0;
      request_byte_pulse = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check_reset_outputs("reset");
      nrst = 1'b1;
      tick();

      // Key 01,00,00,00: first bytes 21 then 05
      load_key(8'h01, 8'h00, 8'h00, 8'h00);
      req_const(8'h21);
      drain();
      req_const(8'h05);
      drain();
      check("overrun_single", 32'(overrun), 32'd0);
      check("ready_idle", 32'(ready), 32'd1);

      // Request during LOAD is ignored without overrun
      key(8'h01);
      key(8'h00);
      request(1'b0, 8'h00);
      check("ready_in_load", 32'(ready), 32'd0);
      check("overrun_load_req", 32'(overrun), 32'd0);
      key(8'h00);
      check("ready_before_4th_b", 32'(ready), 32'd0);
      key(8'h00);
      check("ready_after_4th_b", 32'(ready), 32'd1);
      mx = 32'h1;
      last_due = 0;
      repeat (3) tick();
      req_const(8'h21);
      drain();
      check("overrun_after_load_req", 32'(overrun), 32'd0);

      // All-zero key falls back to the default seed
      load_key(8'h00, 8'h00, 8'h00, 8'h00);
      for (int i = 0; i < 3; i++) begin
         req_model();
         drain();
      end

      // Back-to-back: middle request waits as pending, third is dropped
      load_key(8'h01, 8'h00, 8'h00, 8'h00);
      req_const(8'h21);
      req_const(8'h05);
      request(1'b0, 8'h00);
      check("overrun_set", 32'(overrun), 32'd1);
      drain();
      check("overrun_sticky", 32'(overrun), 32'd1);

      // New key byte while in S2 aborts generation
      load_key(8'h01, 8'h00, 8'h00, 8'h00);
      request(1'b0, 8'h00);
      tick();
      key(8'h78);
      check("ready_after_abort", 32'(ready), 32'd0);
      key(8'h56);
      key(8'h34);
      key(8'h12);
      check("ready_new_key", 32'(ready), 32'd1);
      mx = 32'h1234_5678;
      last_due = 0;
      repeat (4) tick();
      req_model();
      req_model();
      drain();

      // Reset while in S3: outputs clear and no pulse follows
      request(1'b0, 8'h00);
      tick();
      tick();
      #2 nrst = 1'b0;
      #1;
      check_reset_outputs("midreset");
      #1 nrst = 1'b1;
      last_due = 0;
      repeat (6) tick();
      check("ready_after_midreset", 32'(ready), 32'd0);
      check("overrun_after_midreset", 32'(overrun), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
